// File: rtl/conv_relu_maxpool.sv
`default_nettype none
// ============================================================================
//  Module   : conv_relu_maxpool
//  Purpose  : Captures the layer-1 convolution output stream into a feature
//             buffer, then on a pool strobe adds the channel bias, saturates
//             to 8 bits, optionally applies ReLU, and 2x2/stride-2 max-pools
//             the map into the next layer's feature memory.
//  Ports    : clk, rst (sync, active-high)
//             store/address/result : conv pixel write stream (row-major)
//             bias, out_c          : channel bias / channel, latched on pool
//             pool                 : start strobe (ignored while busy)
//             pool_done, busy      : completion pulse / operation in flight
//             wr_en/wr_chan/wr_addr/wr_data : pooled pixel write port
//  Options  : POOL_RELU_EN - when defined, negative pooled results clamp to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_relu_maxpool #(
  parameter int CH           = 26,
  parameter int CW           = 26,
  parameter int ADDR_LEN     = 9,
  parameter int OUT_ADDR_LEN = 7
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    store,
  input  logic [ADDR_LEN:0]       address,
  input  logic signed [7:0]       result,
  input  logic signed [7:0]       bias,
  input  logic [3:0]              out_c,
  input  logic                    pool,
  output logic                    pool_done,
  output logic                    busy,
  output logic                    wr_en,
  output logic [3:0]              wr_chan,
  output logic [OUT_ADDR_LEN:0]   wr_addr,
  output logic signed [7:0]       wr_data
);

  localparam logic [ADDR_LEN:0]     c_npix    = (ADDR_LEN+1)'(CH*CW);
  localparam logic [ADDR_LEN:0]     c_cw      = (ADDR_LEN+1)'(CW);
  localparam logic [ADDR_LEN:0]     c_ph_last = (ADDR_LEN+1)'(CH/2 - 1);
  localparam logic [ADDR_LEN:0]     c_pw_last = (ADDR_LEN+1)'(CW/2 - 1);
  localparam logic [ADDR_LEN:0]     c_one_p   = (ADDR_LEN+1)'(1);
  localparam logic [OUT_ADDR_LEN:0] c_one_w   = (OUT_ADDR_LEN+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                  r_state;
  logic [1:0]              r_sub;      // pixel within window: {row, col}
  logic [ADDR_LEN:0]       r_pr;       // window row
  logic [ADDR_LEN:0]       r_pc;       // window column
  logic [OUT_ADDR_LEN:0]   r_win;      // raster window index
  logic signed [7:0]       r_bias;
  logic signed [7:0]       r_max;
  logic signed [7:0]       r_rd_data;
  logic signed [7:0]       r_buf [CH*CW];

  logic [ADDR_LEN:0]       w_row;
  logic [ADDR_LEN:0]       w_col;
  logic [ADDR_LEN:0]       w_rd_addr;
  logic signed [7:0]       w_max_fin;
  logic signed [8:0]       w_sum;
  logic signed [7:0]       w_sat;
  logic signed [7:0]       w_pix;

  // Pixel address for the current read: (2pr+sub[1])*CW + 2pc+sub[0]
  assign w_row     = (r_pr + r_pr) + {{ADDR_LEN{1'b0}}, r_sub[1]};
  assign w_col     = (r_pc + r_pc) + {{ADDR_LEN{1'b0}}, r_sub[0]};
  assign w_rd_addr = w_row * c_cw + w_col;

  // In WR the fourth pixel is still sitting in the read register.
  assign w_max_fin = (r_rd_data > r_max) ? r_rd_data : r_max;
  assign w_sum     = {w_max_fin[7], w_max_fin} + {r_bias[7], r_bias};

  // Overflow shows as the two top bits of the 9-bit sum disagreeing.
  always_comb begin
    w_sat = w_sum[7:0];
    case ({w_sum[8], w_sum[7]})
      2'b01:   w_sat = 8'sh7F;
      2'b10:   w_sat = 8'sh80;
      default: w_sat = w_sum[7:0];
    endcase
  end

`ifdef POOL_RELU_EN
  assign w_pix = w_sat[7] ? 8'sh00 : w_sat;
`else
  assign w_pix = w_sat;
`endif

  // Feature buffer: write port for capture, registered read for pooling.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && store && address < c_npix) begin
      r_buf[address] <= result;
    end
    r_rd_data <= r_buf[w_rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      pool_done <= 1'b0;
      busy      <= 1'b0;
      wr_en     <= 1'b0;
      wr_chan   <= 4'd0;
      wr_addr   <= '0;
      wr_data   <= 8'sh00;
      r_sub     <= 2'd0;
      r_pr      <= '0;
      r_pc      <= '0;
      r_win     <= '0;
      r_bias    <= 8'sh00;
      r_max     <= 8'sh00;
    end else begin
      wr_en     <= 1'b0;
      pool_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (pool) begin
            r_bias  <= bias;
            wr_chan <= out_c;
            busy    <= 1'b1;
            r_sub   <= 2'd0;
            r_pr    <= '0;
            r_pc    <= '0;
            r_win   <= '0;
            r_state <= S_RD;
          end
        end
        S_RD: begin
          r_sub <= r_sub + 2'd1;
          // Read data lags the address by one cycle: sub==1 sees pixel 0.
          if (r_sub == 2'd1) begin
            r_max <= r_rd_data;
          end else if (r_sub != 2'd0) begin
            r_max <= w_max_fin;
          end
          if (r_sub == 2'd3) begin
            r_state <= S_WR;
          end
        end
        S_WR: begin
          wr_en   <= 1'b1;
          wr_addr <= r_win;
          wr_data <= w_pix;
          r_win   <= r_win + c_one_w;
          if (r_pc == c_pw_last) begin
            r_pc <= '0;
            if (r_pr == c_ph_last) begin
              r_state <= S_DONE;
            end else begin
              r_pr    <= r_pr + c_one_p;
              r_state <= S_RD;
            end
          end else begin
            r_pc    <= r_pc + c_one_p;
            r_state <= S_RD;
          end
        end
        S_DONE: begin
          pool_done <= 1'b1;
          busy      <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_relu_maxpool.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_conv_relu_maxpool
//  Purpose  : Directed self-checking bench for conv_relu_maxpool.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_relu_maxpool;

  localparam int CH           = 26;
  localparam int CW           = 26;
  localparam int ADDR_LEN     = 9;
  localparam int OUT_ADDR_LEN = 7;
  localparam int NWIN         = (CH/2)*(CW/2);
  localparam int NCYC         = 860;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  store;
  logic [ADDR_LEN:0]     address;
  logic signed [7:0]     result;
  logic signed [7:0]     bias;
  logic [3:0]            out_c;
  logic                  pool;
  logic                  pool_done;
  logic                  busy;
  logic                  wr_en;
  logic [3:0]            wr_chan;
  logic [OUT_ADDR_LEN:0] wr_addr;
  logic signed [7:0]     wr_data;

  always #5 clk = ~clk;

  conv_relu_maxpool #(
    .CH(CH), .CW(CW), .ADDR_LEN(ADDR_LEN), .OUT_ADDR_LEN(OUT_ADDR_LEN)
  ) u_dut (
    .clk(clk), .rst(rst), .store(store), .address(address), .result(result),
    .bias(bias), .out_c(out_c), .pool(pool), .pool_done(pool_done),
    .busy(busy), .wr_en(wr_en), .wr_chan(wr_chan), .wr_addr(wr_addr),
    .wr_data(wr_data)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Bench's own image of what the buffer should hold.
  int img [CH*CW];
  int wr_log [NWIN];
  int n_wr, n_done, done_at, space_err, addr_err, busy_err, hold_err, chan_err;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int f_exp(input int m, input int b);
    int s;
    s = m + b;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
`ifdef POOL_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  function automatic int win_exp(input int w, input int b);
    int pr, pc, m, v;
    pr = w / (CW/2);
    pc = w % (CW/2);
    m  = img[(2*pr)*CW + 2*pc];
    for (int dr = 0; dr < 2; dr++) begin
      for (int dc = 0; dc < 2; dc++) begin
        v = img[(2*pr+dr)*CW + 2*pc + dc];
        if (v > m) m = v;
      end
    end
    return f_exp(m, b);
  endfunction

  task automatic put_px(input int a, input int v);
    @(negedge clk);
    store   = 1'b1;
    address = (ADDR_LEN+1)'(a);
    result  = 8'(v);
    if (a < CH*CW) img[a] = v;
  endtask

  task automatic idle_in();
    @(negedge clk);
    store = 1'b0;
  endtask

  task automatic fill_all(input int v);
    for (int a = 0; a < CH*CW; a++) put_px(a, v);
    idle_in();
  endtask

  // mode 0: plain run, 1: re-pool + store at cycle 100, 2: reset at cycle 300
  task automatic run_pool(input int bias_v, input int chan, input int mode);
    logic prev_wr;
    logic exp_busy;
    @(negedge clk);
    bias  = 8'(bias_v);
    out_c = 4'(chan);
    pool  = 1'b1;
    @(posedge clk);
    #1;
    pool = 1'b0;
    n_wr = 0; n_done = 0; done_at = -1; space_err = 0; addr_err = 0;
    busy_err = 0; hold_err = 0; chan_err = 0; prev_wr = 1'b0;
    for (int k = 1; k <= NCYC; k++) begin
      @(posedge clk);
      #1;
      if (mode == 1 && k == 100) begin
        pool = 1'b1; store = 1'b1; address = '0; result = 8'sd99;
      end
      if (mode == 1 && k == 101) begin
        pool = 1'b0; store = 1'b0;
      end
      if (mode == 2 && k == 300) rst = 1'b1;
      if (mode == 2 && k == 301) begin
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_wr_en", int'(wr_en), 0);
        rst = 1'b0;
      end
      if (wr_en) begin
        if ((k % 5) != 0 || prev_wr) space_err++;
        if (n_wr < NWIN) begin
          if (int'(wr_addr) != n_wr) addr_err++;
          wr_log[n_wr] = int'(wr_data);
        end
        if (int'(wr_chan) != chan) chan_err++;
        n_wr++;
      end else if (mode != 2 && n_wr > 0 && int'(wr_addr) != n_wr - 1) begin
        hold_err++;
      end
      prev_wr = wr_en;
      if (pool_done) begin
        n_done++;
        done_at = k;
      end
      if (mode != 2 || k <= 300) begin
        exp_busy = (k < 5*NWIN + 1);
        if (busy !== exp_busy) busy_err++;
      end
    end
  endtask

  task automatic verify_run(input string tag, input int b);
    int derr;
    derr = 0;
    check_eq({tag, "_nwr"},     n_wr, NWIN);
    check_eq({tag, "_ndone"},   n_done, 1);
    check_eq({tag, "_done_at"}, done_at, 5*NWIN + 1);
    check_eq({tag, "_spacing"}, space_err, 0);
    check_eq({tag, "_addr"},    addr_err, 0);
    check_eq({tag, "_busy"},    busy_err, 0);
    check_eq({tag, "_hold"},    hold_err, 0);
    check_eq({tag, "_chan"},    chan_err, 0);
    for (int w = 0; w < NWIN; w++) begin
      if (w < n_wr && wr_log[w] != win_exp(w, b)) derr++;
    end
    check_eq({tag, "_data"}, derr, 0);
  endtask

  initial begin
    int neg_exp;
`ifdef POOL_RELU_EN
    neg_exp = 0;
`else
    neg_exp = 1;
`endif
    rst = 1'b1; store = 1'b0; pool = 1'b0; address = '0; result = '0;
    bias = '0; out_c = '0;
    for (int a = 0; a < CH*CW; a++) img[a] = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_pool_done", int'(pool_done), 0);
    check_eq("rst_busy0",     int'(busy), 0);
    check_eq("rst_wr_en0",    int'(wr_en), 0);
    check_eq("rst_wr_chan",   int'(wr_chan), 0);
    check_eq("rst_wr_addr",   int'(wr_addr), 0);
    check_eq("rst_wr_data",   int'(wr_data), 0);
    @(negedge clk);
    rst = 1'b0;

    // Uniform map: every pooled pixel is 5 + 3.
    fill_all(5);
    run_pool(3, 5, 0);
    verify_run("t1", 3);
    check_eq("t1_first", wr_log[0], 8);
    check_eq("t1_last",  wr_log[NWIN-1], 8);
    check_eq("t1_wr_chan_hold", int'(wr_chan), 5);
    check_eq("t1_busy_after", int'(busy), 0);

    // Mixed-sign first window, plus markers in window 13 and the last window.
    put_px(0, -10); put_px(1, 20); put_px(CW, 7); put_px(CW+1, -3);
    put_px(2*CW+1, 44); put_px(25*CW+25, 60);
    idle_in();
    run_pool(0, 2, 0);
    verify_run("t2", 0);
    check_eq("t2_first", wr_log[0], 20);
    check_eq("t2_win1",  wr_log[1], 5);
    check_eq("t2_win13", wr_log[13], 44);
    check_eq("t2_last",  wr_log[NWIN-1], 60);

    // Positive saturation.
    put_px(0, 120);
    idle_in();
    run_pool(20, 7, 0);
    verify_run("t3", 20);
    check_eq("t3_sat_hi", wr_log[0], 127);
    check_eq("t3_win13",  wr_log[13], 64);

    // Negative saturation, then ReLU.
    put_px(0, -128); put_px(1, -128); put_px(CW, -128); put_px(CW+1, -128);
    idle_in();
    run_pool(-5, 1, 0);
    verify_run("t4", -5);
    check_eq("t4_sat_lo", wr_log[0], neg_exp ? -128 : 0);
    check_eq("t4_win1",   wr_log[1], 0);

    // Uniform negative map.
    fill_all(-50);
    run_pool(10, 3, 0);
    verify_run("t5", 10);
    check_eq("t5_first", wr_log[0], neg_exp ? -40 : 0);
    check_eq("t5_mid",   wr_log[84], neg_exp ? -40 : 0);

    // pool and store while busy must both be ignored.
    run_pool(0, 4, 1);
    verify_run("t6", 0);
    run_pool(0, 4, 0);
    check_eq("t6_buf0_kept", wr_log[0], neg_exp ? -50 : 0);

    // Mid-run reset abandons the operation without pool_done.
    run_pool(0, 9, 2);
    check_eq("t7_no_done", n_done, 0);
    check_eq("t7_partial", n_wr, 60);
    check_eq("t7_busy_idle", int'(busy), 0);
    put_px(CH*CW, 77);
    idle_in();
    run_pool(0, 6, 0);
    verify_run("t7", 0);
    check_eq("t7_first", wr_log[0], neg_exp ? -50 : 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
